// File: rtl/gate_truth_table_sequencer_if.sv
// Bundle between the truth-table sequencer and its surroundings: run control,
// the gate-under-test stimulus/response pair, and the result vectors.
interface gate_truth_table_sequencer_if #(
    parameter int N_IN = 3
);
    localparam int T = 1 << N_IN;

    // start is a level request sampled only in IDLE; busy covers the run and
    // done pulses for one cycle when the results below become final.
    logic            start;
    logic [N_IN-1:0] x_out;
    logic            y_in;
    logic            busy;
    logic            done;
    logic            pass;
    logic [T-1:0]    observed;
    logic [T-1:0]    mismatch;
    logic [N_IN:0]   fail_count;
    logic [1:0]      state_dbg;

    modport master (
        input  start, y_in,
        output x_out, busy, done, pass, observed, mismatch, fail_count, state_dbg
    );

    modport slave (
        output start, y_in,
        input  x_out, busy, done, pass, observed, mismatch, fail_count, state_dbg
    );
endinterface

// File: rtl/gate_truth_table_sequencer.sv
// Walks every input code of an N_IN-input gate, holds each for SETTLE cycles,
// samples the gate output and accumulates observed/mismatch tables and a pass flag.
module gate_truth_table_sequencer #(
    parameter int                    N_IN     = 3,
    parameter int                    SETTLE   = 5,
    parameter logic [(1<<N_IN)-1:0]  EXPECTED = 8'b1000_0000
) (
    input  logic                          clk,
    input  logic                          rst,
    gate_truth_table_sequencer_if.master  bus
);
    localparam int T  = 1 << N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0] x_q, x_d;
    logic [T-1:0]    obs_q, obs_d;
    logic [T-1:0]    mis_q, mis_d;
    logic [N_IN:0]   fc_q, fc_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            y_unknown;
    logic            bit_mis;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            obs_q   <= '0;
            mis_q   <= '0;
            fc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            obs_q   <= obs_d;
            mis_q   <= mis_d;
            fc_q    <= fc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        obs_d   = obs_q;
        mis_d   = mis_q;
        fc_d    = fc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;

        // An undriven or contended gate output always counts as a failure.
        y_unknown = $isunknown(bus.y_in);
        bit_mis   = y_unknown || (bus.y_in != EXPECTED[x_q]);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    x_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    obs_d   = '0;
                    mis_d   = '0;
                    fc_d    = '0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    obs_d[x_q] = !y_unknown && bus.y_in;
                    mis_d[x_q] = bit_mis;
                    fc_d       = fc_q + (N_IN+1)'(bit_mis);
                    // Last code is checked before incrementing so x_out never wraps.
                    if (x_q == {N_IN{1'b1}}) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (fc_d == '0);
                    end else begin
                        x_d   = x_q + N_IN'(1);
                        cnt_d = '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.x_out      = x_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.observed   = obs_q;
    assign bus.mismatch   = mis_q;
    assign bus.fail_count = fc_q;
    assign bus.state_dbg  = state_q;
endmodule
